// File: rtl/watch2count.sv
// Converts a preset elapsed time given as hr:min:s.ms display fields into the
// raw millisecond count that seeds the stopwatch pulse counter.
module watch2count #(
    parameter int BITS = 26
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [9:0]      ms,
    input  logic [5:0]      s,
    input  logic [5:0]      min,
    input  logic [6:0]      hr,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            ovf,
    output logic [BITS-1:0] count
);

    // Largest legal time is 35,999,999 ms, which fits in 26 bits.
    localparam int ACC_W = 26;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        MUL_S,
        MUL_MS
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        ms_q, ms_d;
    logic [5:0]        s_q, s_d;
    logic [5:0]        min_q, min_d;
    logic [6:0]        hr_q, hr_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [BITS-1:0]   count_q, count_d;

    logic              fields_ok;
    logic [ACC_W-1:0]  final_acc;
    logic [BITS-1:0]   count_fit;
    logic              acc_ovf;

    function automatic logic [ACC_W-1:0] mul60(input logic [ACC_W-1:0] x);
        return (x << 6) - (x << 2);
    endfunction

    function automatic logic [ACC_W-1:0] mul1000(input logic [ACC_W-1:0] x);
        return (x << 10) - (x << 4) - (x << 3);
    endfunction

    assign fields_ok = (ms_q <= 10'd999) && (s_q <= 6'd59) &&
                       (min_q <= 6'd59) && (hr_q <= 7'd9);

    assign final_acc = mul1000(acc_q) + ACC_W'(ms_q);

    // Fit the 26-bit result into the output width and flag lost high bits.
    generate
        if (BITS < ACC_W) begin : g_narrow
            assign count_fit = final_acc[BITS-1:0];
            assign acc_ovf   = |final_acc[ACC_W-1:BITS];
        end else if (BITS == ACC_W) begin : g_exact
            assign count_fit = final_acc;
            assign acc_ovf   = 1'b0;
        end else begin : g_wide
            assign count_fit = {{(BITS-ACC_W){1'b0}}, final_acc};
            assign acc_ovf   = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        s_d     = s_q;
        min_d   = min_q;
        hr_d    = hr_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ovf_d   = ovf_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ms_d    = ms;
                    s_d     = s;
                    min_d   = min;
                    hr_d    = hr;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!fields_ok) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d   = mul60(ACC_W'(hr_q)) + ACC_W'(min_q);
                    state_d = MUL_S;
                end
            end
            MUL_S: begin
                acc_d   = mul60(acc_q) + ACC_W'(s_q);
                state_d = MUL_MS;
            end
            MUL_MS: begin
                acc_d   = final_acc;
                count_d = count_fit;
                ovf_d   = acc_ovf;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ms_q    <= '0;
            s_q     <= '0;
            min_q   <= '0;
            hr_q    <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            s_q     <= s_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign ovf   = ovf_q;
    assign count = count_q;

endmodule

// File: tb/tb_watch2count.sv
// Scoreboard bench for watch2count: a 26-bit and a 16-bit instance side by side,
// expected results queued at acceptance and compared when done pulses.
module tb_watch2count;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, start_a, start_b;
    logic [9:0]  ms_f;
    logic [5:0]  s_f, min_f;
    logic [6:0]  hr_f;
    logic        busy_a, done_a, err_a, ovf_a;
    logic        busy_b, done_b, err_b, ovf_b;
    logic [25:0] count_a;
    logic [15:0] count_b;

    watch2count #(.BITS(26)) u_a (
        .clk(clk), .reset(rst_a), .start(start_a),
        .ms(ms_f), .s(s_f), .min(min_f), .hr(hr_f),
        .busy(busy_a), .done(done_a), .err(err_a), .ovf(ovf_a), .count(count_a)
    );

    watch2count #(.BITS(16)) u_b (
        .clk(clk), .reset(rst_b), .start(start_b),
        .ms(ms_f), .s(s_f), .min(min_f), .hr(hr_f),
        .busy(busy_b), .done(done_b), .err(err_b), .ovf(ovf_b), .count(count_b)
    );

    typedef struct {
        longint cnt;
        bit     err;
        bit     ovf;
        int     acc_cyc;
        int     lat;
    } exp_t;

    exp_t   q_a[$];
    exp_t   q_b[$];
    longint model_count [2];
    int     cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, req, cyc);
        end
    endtask

    task automatic check_done(input int sel);
        exp_t e;
        string p;
        p = (sel == 0) ? "A" : "B";
        if ((sel == 0 && q_a.size() == 0) || (sel == 1 && q_b.size() == 0)) begin
            check({p, ".spurious_done"}, 1, 0);
            return;
        end
        if (sel == 0) begin
            e = q_a.pop_front();
            check("A.count", 64'(count_a), e.cnt);
            check("A.err", err_a, e.err);
            check("A.ovf", ovf_a, e.ovf);
            check("A.busy_at_done", busy_a, 0);
            $display("[TB] A done count=%0d err=%0d ovf=%0d", count_a, err_a, ovf_a);
        end else begin
            e = q_b.pop_front();
            check("B.count", 64'(count_b), e.cnt);
            check("B.err", err_b, e.err);
            check("B.ovf", ovf_b, e.ovf);
            check("B.busy_at_done", busy_b, 0);
            $display("[TB] B done count=%0d err=%0d ovf=%0d", count_b, err_b, ovf_b);
        end
        check({p, ".latency"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
    endtask

    always @(negedge clk) if (done_a) check_done(0);
    always @(negedge clk) if (done_b) check_done(1);

    // Drive one start pulse; when push is set the request must be accepted.
    task automatic send(input int sel, input int h, input int m, input int sec,
                        input int msec, input bit push);
        exp_t   e;
        longint full;
        longint lim;
        bit     valid;
        hr_f  = 7'(h);
        min_f = 6'(m);
        s_f   = 6'(sec);
        ms_f  = 10'(msec);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        hr_f  = 7'($urandom);
        min_f = 6'($urandom);
        s_f   = 6'($urandom);
        ms_f  = 10'($urandom);
        if (push) begin
            valid = (msec <= 999) && (sec <= 59) && (m <= 59) && (h <= 9);
            full  = longint'(h) * 3600000 + longint'(m) * 60000 + longint'(sec) * 1000 + msec;
            lim   = (sel == 0) ? (64'd1 << 26) : (64'd1 << 16);
            e.acc_cyc = cyc;
            if (valid) begin
                e.cnt = full % lim;
                e.ovf = (full >= lim);
                e.err = 1'b0;
                e.lat = 3;
                model_count[sel] = e.cnt;
            end else begin
                e.cnt = model_count[sel];
                e.ovf = 1'b0;
                e.err = 1'b1;
                e.lat = 1;
            end
            if (sel == 0) begin
                check("A.accept_busy", busy_a, 1);
                check("A.accept_err_clr", err_a, 0);
                q_a.push_back(e);
            end else begin
                check("B.accept_busy", busy_b, 1);
                check("B.accept_ovf_clr", ovf_b, 0);
                q_b.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input int sel);
        for (int i = 0; i < 20; i++) begin
            if ((sel == 0 && q_a.size() == 0) || (sel == 1 && q_b.size() == 0)) break;
            @(posedge clk); #1;
        end
        if (sel == 0) begin
            check("A.timeout", q_a.size(), 0);
            q_a.delete();
        end else begin
            check("B.timeout", q_b.size(), 0);
            q_b.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        ms_f = '0; s_f = '0; min_f = '0; hr_f = '0;
        model_count[0] = 0;
        model_count[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        check("A.rst_busy", busy_a, 0);
        check("A.rst_done", done_a, 0);
        check("A.rst_err", err_a, 0);
        check("A.rst_ovf", ovf_a, 0);
        check("A.rst_count", 64'(count_a), 0);
        check("B.rst_busy", busy_b, 0);
        check("B.rst_count", 64'(count_b), 0);

        // Directed conversions on the full-width instance
        send(0, 1, 2, 3, 456, 1);  wait_done(0);
        send(0, 9, 59, 59, 999, 1); wait_done(0);
        send(0, 0, 0, 0, 0, 1);    wait_done(0);
        send(0, 0, 0, 0, 5, 1);    wait_done(0);
        send(0, 0, 0, 60, 0, 1);   wait_done(0);
        repeat (3) @(posedge clk);
        #1;
        check("A.err_held", err_a, 1);
        check("A.count_held", 64'(count_a), 5);
        send(0, 1, 2, 3, 456, 1);  wait_done(0);
        send(0, 0, 0, 0, 1000, 1); wait_done(0);
        send(0, 0, 60, 0, 0, 1);   wait_done(0);
        send(0, 10, 0, 0, 0, 1);   wait_done(0);

        for (int i = 0; i < 6; i++) begin
            send(0, $urandom_range(0, 9), $urandom_range(0, 59),
                 $urandom_range(0, 59), $urandom_range(0, 999), 1);
            wait_done(0);
        end

        // Start while busy is ignored; fields were latched at acceptance
        send(0, 2, 3, 4, 5, 1);
        send(0, 7, 7, 7, 7, 0);
        wait_done(0);

        // Start during the done cycle is accepted
        send(0, 3, 14, 15, 926, 1);
        repeat (3) @(posedge clk);
        #1;
        check("A.done_before_b2b", done_a, 1);
        send(0, 5, 35, 8, 979, 1);
        wait_done(0);

        // Reset during MUL_S aborts without a done pulse
        send(0, 4, 4, 4, 4, 0);
        @(posedge clk); #1;
        check("A.busy_in_mul_s", busy_a, 1);
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        model_count[0] = 0;
        check("A.abort_busy", busy_a, 0);
        check("A.abort_count", 64'(count_a), 0);
        check("A.abort_done", done_a, 0);
        repeat (6) @(posedge clk);
        #1;

        // Reset and start together: reset wins
        rst_a = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        start_a = 1'b0;
        check("A.rst_beats_start", busy_a, 0);
        repeat (4) @(posedge clk);
        #1;

        // Narrow instance: truncation and overflow flag
        send(1, 0, 1, 5, 536, 1);  wait_done(1);
        send(1, 0, 1, 5, 535, 1);  wait_done(1);
        for (int i = 0; i < 4; i++) begin
            send(1, $urandom_range(0, 9), $urandom_range(0, 59),
                 $urandom_range(0, 59), $urandom_range(0, 999), 1);
            wait_done(1);
        end
        send(1, 0, 0, 0, 1001, 1); wait_done(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
